inst_fetch: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder. Owns the PC and issues
//  in-order word reads to instruction memory over a valid/ready request channel.

---
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads under a credit limit
// and queues returned words for decode. Redirects flush queued and in-flight fetches.
module inst_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int              CNT_W    = $clog2(QUEUE_DEPTH + 1);
   localparam int              PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [CNT_W:0]  DEPTH_C  = (CNT_W + 1)'(QUEUE_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [31:0]     NOP      = 32'h0000_0013;

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  discard_q, discard_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic              req_valid_q, req_valid_d;

   logic [31:0]       mem_inst_q [QUEUE_DEPTH];
   logic [31:0]       mem_pc_q   [QUEUE_DEPTH];

   logic              accept;
   logic              push;
   logic              pop;
   logic [31:0]       resp_pc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      accept = req_valid_q & imem_req_ready;
      pop    = (fifo_count_q != '0) & inst_ready;
      push   = imem_resp_valid & (discard_q == '0) & ~redirect_valid;
      // With nothing to discard, every in-flight request is contiguous and ends just below pc_q,
      // so the oldest one (the responder) sits outstanding words behind it.
      resp_pc = pc_q - 32'({outstanding_q, 2'b00});

      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_resp_valid);
      pc_d          = accept ? pc_q + 32'd4 : pc_q;
      fifo_count_d  = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d      = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      discard_d     = discard_q - CNT_W'(imem_resp_valid && (discard_q != '0));

      state_d = state_q;
      if (state_q == S_FLUSH && discard_d == '0) begin
         state_d = S_FETCH;
      end

      if (redirect_valid) begin
         pc_d         = redirect_pc & ~32'h3;
         fifo_count_d = '0;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         discard_d    = outstanding_d;
         state_d      = (outstanding_d != '0) ? S_FLUSH : S_FETCH;
      end

      req_valid_d = (state_d == S_FETCH) &&
                    (({1'b0, fifo_count_d} + {1'b0, outstanding_d}) < DEPTH_C);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         fifo_count_q  <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         req_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fifo_count_q  <= fifo_count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         req_valid_q   <= req_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst_q[wr_ptr_q] <= imem_resp_data;
         mem_pc_q[wr_ptr_q]   <= resp_pc;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (fifo_count_q != '0);
   assign inst           = inst_valid ? mem_inst_q[rd_ptr_q] : NOP;
   assign inst_pc        = inst_valid ? mem_pc_q[rd_ptr_q] : pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run, all checked against
// an instruction-stream model (sequential words from the last redirect target).
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t       mq[$];
   logic [31:0] mem_key;
   int          lat_min = 1, lat_max = 1, resp_pct = 100;
   int          n_cmp = 0, n_fail = 0, cyc = 0;
   logic [31:0] exp_pc, exp_req;
   logic        pop_o, acc_o;
   logic [31:0] pi_o, pp_o, aa_o;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ mem_key;
   endfunction

   // One clock: sample outputs, model the memory, drive inputs for the coming edge.
   task automatic step(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc,
                       output logic popped, output logic [31:0] p_inst, output logic [31:0] p_pc,
                       output logic acc, output logic [31:0] a_addr);
      @(negedge clk);
      cyc++;
      acc    = imem_req_valid && rdy;
      a_addr = imem_req_addr;
      popped = inst_valid && irdy;
      p_inst = inst;
      p_pc   = inst_pc;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = word_at(mq[0].addr);
         void'(mq.pop_front());
      end
      if (acc) mq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      imem_req_ready = rdy;
      inst_ready     = irdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
   endtask

   task automatic do_reset(input logic [31:0] key);
      @(negedge clk);
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
      mq.delete();
      mem_key = key; lat_min = 1; lat_max = 1; resp_pct = 100;
      @(negedge clk);
      rst_n = 1'b1;
      exp_pc = RESET_PC;
      exp_req = RESET_PC;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b exp 0", imem_req_valid); end
      n_cmp++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h exp %h", imem_req_addr, RESET_PC); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b exp 0", inst_valid); end
      n_cmp++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h exp %h", inst, NOP); end
      n_cmp++; if (inst_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_inst_pc: got %h exp %h", inst_pc, RESET_PC); end
   endtask

   task automatic test_stream();
      int first_acc, first_pop, pops;
      first_acc = -1; first_pop = -1; pops = 0;
      do_reset(32'h0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            if (first_acc < 0) first_acc = cyc;
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL stream_req_addr: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
         if (pop_o) begin
            if (first_pop < 0) first_pop = cyc;
            pops++;
            n_cmp++; if (pp_o !== exp_pc) begin n_fail++; $display("FAIL stream_inst_pc: got %h exp %h", pp_o, exp_pc); end
            n_cmp++; if (pi_o !== pp_o) begin n_fail++; $display("FAIL stream_inst_eq_pc: got %h exp %h", pi_o, pp_o); end
            exp_pc += 32'd4;
         end
      end
      n_cmp++; if (first_pop - first_acc !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d exp 2", first_pop - first_acc); end
      n_cmp++; if (pops < 20) begin n_fail++; $display("FAIL stream_throughput: got %0d exp >=20", pops); end
   endtask

   task automatic test_backpressure();
      int accs, pops;
      accs = 0; pops = 0;
      do_reset($urandom());
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            accs++;
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL bp_req_addr: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
      end
      n_cmp++; if (accs !== 2) begin n_fail++; $display("FAIL bp_req_count: got %0d exp 2", accs); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid_full: got %b exp 0", imem_req_valid); end
      n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_inst_valid: got %b exp 1", inst_valid); end
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL bp_req_addr2: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
         if (pop_o) begin
            pops++;
            n_cmp++; if (pp_o !== exp_pc || pi_o !== word_at(exp_pc)) begin n_fail++; $display("FAIL bp_inst: got pc %h inst %h exp pc %h inst %h", pp_o, pi_o, exp_pc, word_at(exp_pc)); end
            exp_pc += 32'd4;
         end
      end
      n_cmp++; if (pops < 3) begin n_fail++; $display("FAIL bp_drain: got %0d exp >=3", pops); end
   endtask

   task automatic test_flush();
      int accs;
      logic [31:0] first_a, first_p;
      accs = 0; first_a = 32'hDEAD_BEEF; first_p = 32'hDEAD_BEEF;
      do_reset($urandom());
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 10 && accs < 2; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            accs++;
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL flush_req_addr: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
      end
      n_cmp++; if (accs !== 2) begin n_fail++; $display("FAIL flush_setup: got %0d exp 2", accs); end
      step(1'b1, 1'b1, 1'b1, 32'h0000_0103, pop_o, pi_o, pp_o, acc_o, aa_o);
      n_cmp++; if (acc_o !== 1'b0 || pop_o !== 1'b0) begin n_fail++; $display("FAIL flush_credit: got acc %b pop %b exp 0 0", acc_o, pop_o); end
      exp_req = 32'h0000_0100; exp_pc = 32'h0000_0100;
      @(posedge clk); #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_req: got %b exp 0", imem_req_valid); end
      for (int i = 0; i < 25; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            if (first_a === 32'hDEAD_BEEF) first_a = aa_o;
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL flush_req_addr2: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
         if (pop_o) begin
            if (first_p === 32'hDEAD_BEEF) first_p = pp_o;
            n_cmp++; if (pp_o !== exp_pc || pi_o !== word_at(exp_pc)) begin n_fail++; $display("FAIL flush_inst: got pc %h inst %h exp pc %h inst %h", pp_o, pi_o, exp_pc, word_at(exp_pc)); end
            exp_pc += 32'd4;
         end
      end
      n_cmp++; if (first_a !== 32'h0000_0100) begin n_fail++; $display("FAIL flush_first_addr: got %h exp 00000100", first_a); end
      n_cmp++; if (first_p !== 32'h0000_0100) begin n_fail++; $display("FAIL flush_first_pc: got %h exp 00000100", first_p); end
   endtask

   task automatic test_collide();
      logic [31:0] first_p;
      first_p = 32'hDEAD_BEEF;
      do_reset($urandom());
      step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
      n_cmp++; if (acc_o !== 1'b1 || aa_o !== RESET_PC) begin n_fail++; $display("FAIL collide_acc0: got %b/%h exp 1/%h", acc_o, aa_o, RESET_PC); end
      step(1'b1, 1'b1, 1'b1, 32'h0000_0200, pop_o, pi_o, pp_o, acc_o, aa_o);
      n_cmp++; if (acc_o !== 1'b1 || aa_o !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL collide_acc1: got %b/%h exp 1/%h", acc_o, aa_o, RESET_PC + 32'd4); end
      exp_req = 32'h0000_0200; exp_pc = 32'h0000_0200;
      @(posedge clk); #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL collide_no_req: got %b exp 0", imem_req_valid); end
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL collide_req_addr: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
         if (pop_o) begin
            if (first_p === 32'hDEAD_BEEF) first_p = pp_o;
            n_cmp++; if (pp_o !== exp_pc || pi_o !== word_at(exp_pc)) begin n_fail++; $display("FAIL collide_inst: got pc %h inst %h exp pc %h inst %h", pp_o, pi_o, exp_pc, word_at(exp_pc)); end
            exp_pc += 32'd4;
         end
      end
      n_cmp++; if (first_p !== 32'h0000_0200) begin n_fail++; $display("FAIL collide_first_pc: got %h exp 00000200", first_p); end
   endtask

   task automatic test_wrap();
      logic [31:0] addrs[$];
      do_reset($urandom());
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, pop_o, pi_o, pp_o, acc_o, aa_o);
      exp_req = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            addrs.push_back(aa_o);
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL wrap_req_addr: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
         if (pop_o) begin
            n_cmp++; if (pp_o !== exp_pc || pi_o !== word_at(exp_pc)) begin n_fail++; $display("FAIL wrap_inst: got pc %h inst %h exp pc %h inst %h", pp_o, pi_o, exp_pc, word_at(exp_pc)); end
            exp_pc += 32'd4;
         end
      end
      n_cmp++;
      if (addrs.size() < 2) begin
         n_fail++; $display("FAIL wrap_count: got %0d exp >=2", addrs.size());
      end else if (addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000) begin
         n_fail++; $display("FAIL wrap_addr: got %h,%h exp fffffffc,00000000", addrs[0], addrs[1]);
      end
   endtask

   task automatic test_reset_mid();
      int pops;
      pops = 0;
      do_reset($urandom());
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
      n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_full: got %b exp 1", inst_valid); end
      @(negedge clk);
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
      mq.delete();
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_inst_valid: got %b exp 0", inst_valid); end
      n_cmp++; if (inst !== NOP) begin n_fail++; $display("FAIL rmid_inst: got %h exp %h", inst, NOP); end
      n_cmp++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL rmid_req_addr: got %h exp %h", imem_req_addr, RESET_PC); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_req_valid: got %b exp 0", imem_req_valid); end
      rst_n = 1'b1;
      exp_pc = RESET_PC; exp_req = RESET_PC;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (acc_o) begin
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL rmid_req_addr2: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
         if (pop_o) begin
            pops++;
            n_cmp++; if (pp_o !== exp_pc || pi_o !== word_at(exp_pc)) begin n_fail++; $display("FAIL rmid_inst2: got pc %h inst %h exp pc %h inst %h", pp_o, pi_o, exp_pc, word_at(exp_pc)); end
            exp_pc += 32'd4;
         end
      end
      n_cmp++; if (pops < 2) begin n_fail++; $display("FAIL rmid_recover: got %0d exp >=2", pops); end
   endtask

   task automatic test_random();
      int pops;
      logic pv, prev_acc, prev_redir, rdy, irdy, rd;
      logic [31:0] pa, rpc;
      pops = 0; pv = 1'b0; prev_acc = 1'b0; prev_redir = 1'b0; pa = 32'h0;
      do_reset($urandom());
      lat_min = 1; lat_max = 4; resp_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         rdy  = ($urandom_range(99) < 70);
         irdy = ($urandom_range(99) < 60);
         rd   = ($urandom_range(99) < 3);
         rpc  = $urandom();
         step(rdy, irdy, rd, rpc, pop_o, pi_o, pp_o, acc_o, aa_o);
         if (pv && !prev_acc && !prev_redir) begin
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== pa) begin n_fail++; $display("FAIL rand_req_hold: got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, pa); end
         end
         pv = imem_req_valid; pa = imem_req_addr; prev_acc = acc_o; prev_redir = rd;
         if (acc_o) begin
            n_cmp++; if (aa_o !== exp_req) begin n_fail++; $display("FAIL rand_req_addr: got %h exp %h", aa_o, exp_req); end
            exp_req += 32'd4;
         end
         if (pop_o) begin
            pops++;
            n_cmp++; if (pp_o !== exp_pc || pi_o !== word_at(exp_pc)) begin n_fail++; $display("FAIL rand_inst: got pc %h inst %h exp pc %h inst %h", pp_o, pi_o, exp_pc, word_at(exp_pc)); end
            exp_pc += 32'd4;
         end
         if (rd) begin
            exp_req = rpc & ~32'h3;
            exp_pc  = rpc & ~32'h3;
         end
         n_cmp++; if (mq.size() > DEPTH) begin n_fail++; $display("FAIL rand_outstanding: got %0d exp <=%0d", mq.size(), DEPTH); end
      end
      n_cmp++; if (pops < 100) begin n_fail++; $display("FAIL rand_progress: got %0d exp >=100", pops); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_collide();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
